// File: rtl/bsg_div_iterative_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package bsg_div_iterative_pkg;

  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eCAL  = 2'd1,
    eFIX  = 2'd2,
    eDONE = 2'd3
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int safe_clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bsg_div_iterative_step.sv
// One combinational restoring-division stage: shift in one dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module bsg_div_iterative_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               dividend_bit_i,
  output logic [width_p-1:0] rem_o,
  output logic               q_o
);

  // The running remainder keeps its msb so divisors above 2^(width_p-1)
  // still compare correctly; the borrow bit of the wide subtract is the compare.
  logic [width_p:0]   partial;
  logic [width_p+1:0] diff;

  assign partial = {rem_i, dividend_bit_i};
  assign diff    = {1'b0, partial} - {2'b00, divisor_i};
  assign q_o     = ~diff[width_p+1];
  assign rem_o   = q_o ? diff[width_p-1:0] : partial[width_p-1:0];

endmodule

// File: rtl/bsg_div_iterative_restoring.sv
// Iterative signed/unsigned integer divider, iter_step_p quotient bits per cycle.
// Optional build macro BSG_DIV_ITERATIVE_DIV0_FAST_EN: a zero divisor skips the
// iteration and the result is valid one cycle after the handshake.
//
// Handshake: operands are taken on a clock edge where v_i & ready_o; ready_o stays
// low until the result is consumed. The result is offered with v_o=1 and held
// stable until a clock edge where yumi_i=1, after which ready_o returns next cycle.
module bsg_div_iterative_restoring
  import bsg_div_iterative_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int iter_step_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               v_o,
  input  logic               yumi_i,
  output state_e             state_o
);

  localparam int n_lp     = width_p / iter_step_p;
  localparam int cnt_w_lp = safe_clog2(n_lp);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(n_lp - 1);

  state_e              state_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic [width_p-1:0]  quo_r;   // dividend bits shift out the top, quotient bits in the bottom
  logic [width_p-1:0]  rem_r;
  logic [width_p-1:0]  dvs_r;
  logic                neg_q_r;
  logic                neg_r_r;

  // Operand magnitudes and sign flags at the handshake
  logic               dividend_neg, divisor_neg;
  logic [width_p-1:0] dividend_abs, divisor_abs;

  assign dividend_neg = signed_i & dividend_i[width_p-1];
  assign divisor_neg  = signed_i & divisor_i[width_p-1];
  assign dividend_abs = dividend_neg ? (-dividend_i) : dividend_i;
  assign divisor_abs  = divisor_neg  ? (-divisor_i)  : divisor_i;

  // Cascade of restoring stages resolving iter_step_p quotient bits per cycle
  logic [width_p-1:0]     rem_chain [iter_step_p+1];
  logic [iter_step_p-1:0] q_bits;
  logic [width_p-1:0]     quo_next;

  assign rem_chain[0] = rem_r;

  for (genvar k = 0; k < iter_step_p; k++) begin : g_step
    bsg_div_iterative_step #(.width_p(width_p)) u_step (
      .rem_i          (rem_chain[k]),
      .divisor_i      (dvs_r),
      .dividend_bit_i (quo_r[width_p-1-k]),
      .rem_o          (rem_chain[k+1]),
      .q_o            (q_bits[iter_step_p-1-k])
    );
  end

  assign quo_next = (quo_r << iter_step_p) | width_p'(q_bits);

  // Sign correction; a zero divisor leaves the all-ones quotient untouched
  logic [width_p-1:0] quo_fix, rem_fix;

  assign quo_fix = (neg_q_r && (dvs_r != '0)) ? (-quo_r) : quo_r;
  assign rem_fix = neg_r_r ? (-rem_r) : rem_r;

  assign state_o = state_r;

  // Control FSM and datapath registers with registered handshake outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= eIDLE;
      cnt_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      dvs_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      ready_o     <= 1'b1;
      v_o         <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (state_r)
        eIDLE: begin
          if (v_i && ready_o) begin
            ready_o <= 1'b0;
            quo_r   <= dividend_abs;
            rem_r   <= '0;
            dvs_r   <= divisor_abs;
            neg_q_r <= dividend_neg ^ divisor_neg;
            neg_r_r <= dividend_neg;
            cnt_r   <= '0;
`ifdef BSG_DIV_ITERATIVE_DIV0_FAST_EN
            if (divisor_i == '0) begin
              state_r     <= eDONE;
              v_o         <= 1'b1;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else begin
              state_r <= eCAL;
            end
`else
            state_r <= eCAL;
`endif
          end
        end
        eCAL: begin
          quo_r <= quo_next;
          rem_r <= rem_chain[iter_step_p];
          if (cnt_r == cnt_last_lp) begin
            cnt_r   <= '0;
            state_r <= eFIX;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        eFIX: begin
          quotient_o  <= quo_fix;
          remainder_o <= rem_fix;
          v_o         <= 1'b1;
          state_r     <= eDONE;
        end
        eDONE: begin
          if (yumi_i) begin
            state_r     <= eIDLE;
            v_o         <= 1'b0;
            ready_o     <= 1'b1;
            quo_r       <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
          end
        end
        default: begin
          state_r <= eIDLE;
          ready_o <= 1'b1;
          v_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_div_iterative_restoring.sv
// Self-checking bench for bsg_div_iterative_restoring (width 32).
// Honours BSG_DIV_ITERATIVE_DIV0_FAST_EN for the divide-by-zero latency.
module tb_bsg_div_iterative_restoring;
  import bsg_div_iterative_pkg::*;

  localparam int W         = 32;
  localparam int ITER_STEP = 4;
  localparam int N         = W / ITER_STEP;

  logic         clk;
  logic         reset_n;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         v_o;
  logic         yumi;
  state_e       state;

  bsg_div_iterative_restoring #(.width_p(W), .iter_step_p(ITER_STEP)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .signed_i    (signed_in),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .v_o         (v_o),
    .yumi_i      (yumi),
    .state_o     (state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           acc;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   next_id  = 0;
  int   seen_id  = -1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // behavioural model: plain arithmetic on the operands
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint       sa, sb, sq, sr;
    sa = 0; sb = 0; sq = 0; sr = 0;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
    end
    return {q, r};
  endfunction

  function automatic int model_latency(input logic [W-1:0] b);
`ifdef BSG_DIV_ITERATIVE_DIV0_FAST_EN
    if (b == '0) return 1;
`endif
    return N + 2;
  endfunction

  // compare process: every cycle v_o is high the outputs must match the model
  always @(negedge clk) begin
    if (reset_n && v_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_v_o", W'(v_o), '0);
      end else begin
        check("model_q", quotient, exp_q[0].q);
        check("model_r", remainder, exp_q[0].r);
        check("ready_low_while_v_o", W'(ready_o), '0);
        if (exp_q[0].id != seen_id) begin
          seen_id = exp_q[0].id;
          check("latency", W'(cyc - exp_q[0].acc), W'(exp_q[0].lat));
        end
      end
    end
  end

  // driver: issue one operation, check hand values, hold, consume
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int hold);
    int           budget;
    logic [2*W-1:0] m;
    exp_t         e;
    budget = 0;
    while (!ready_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!ready_o) begin
      check({name, "_ready_timeout"}, W'(ready_o), W'(1));
      return;
    end
    dividend  = a;
    divisor   = b;
    signed_in = s;
    v_i       = 1'b1;
    m     = model(a, b, s);
    e.q   = m[2*W-1:W];
    e.r   = m[W-1:0];
    e.lat = model_latency(b);
    e.acc = cyc;
    e.id  = next_id;
    next_id++;
    exp_q.push_back(e);
    @(negedge clk);
    v_i = 1'b0;
    budget = 0;
    while (!v_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!v_o) begin
      check({name, "_v_o_timeout"}, W'(v_o), W'(1));
      void'(exp_q.pop_front());
      return;
    end
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    for (int i = 0; i < hold; i++) begin
      v_i       = 1'b1;
      dividend  = $urandom;
      divisor   = W'($urandom_range(0, 255));
      signed_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({name, "_bp_ready"}, W'(ready_o), '0);
      check({name, "_bp_v_o"}, W'(v_o), W'(1));
      check({name, "_bp_q"}, quotient, eq);
      check({name, "_bp_r"}, remainder, er);
    end
    v_i  = 1'b0;
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    void'(exp_q.pop_front());
    check({name, "_ready_after_yumi"}, W'(ready_o), W'(1));
    check({name, "_v_o_after_yumi"}, W'(v_o), '0);
    check({name, "_q_cleared"}, quotient, '0);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           hold;
  } vec_t;

  vec_t vecs[12];

  // stimulus
  initial begin
    vecs[0]  = '{"u_100_7",       32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          10};
    vecs[1]  = '{"s_m100_7",      32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   0};
    vecs[2]  = '{"s_100_m7",      32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1};
    vecs[3]  = '{"s_overflow",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          0};
    vecs[4]  = '{"u_min_allones", 32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   0};
    vecs[5]  = '{"u_div0",        32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          2};
    vecs[6]  = '{"s_m5_div0",     32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   0};
    vecs[7]  = '{"s_5_div0",      32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          0};
    vecs[8]  = '{"s_m7_m2",       32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   0};
    vecs[9]  = '{"u_big_divisor", 32'hFFFFFFFF,   32'h80000001,   1'b0, 32'd1,          32'h7FFFFFFE,   0};
    vecs[10] = '{"u_div1",        32'h12345678,   32'd1,          1'b0, 32'h12345678,   32'd0,          0};
    vecs[11] = '{"u_1000_33",     32'd1000,       32'd33,         1'b0, 32'd30,         32'd10,         0};

    reset_n   = 1'b0;
    v_i       = 1'b0;
    yumi      = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", W'(ready_o), W'(1));
    check("reset_v_o", W'(v_o), '0);
    check("reset_q", quotient, '0);
    check("reset_r", remainder, '0);
    check("reset_state", W'(state), W'(eIDLE));
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].hold);

    // reset asserted in the middle of the iteration
    dividend  = 32'hFFFFFFFF;
    divisor   = 32'd3;
    signed_in = 1'b0;
    v_i       = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_cal_state", W'(state), W'(eCAL));
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_ready", W'(ready_o), W'(1));
    check("mid_reset_v_o", W'(v_o), '0);
    check("mid_reset_q", quotient, '0);
    check("mid_reset_r", remainder, '0);
    check("mid_reset_state", W'(state), W'(eIDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 32'hFFFFFFFF, 32'd16, 1'b0, 32'h0FFFFFFF, 32'd15, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
